// File: rtl/npu_loader_pkg.sv
// npu_loader_pkg: shared state encoding, lane-mask helpers and default lane masks
// for the npu_simple operand buffer loader.
// Build option: NPU_LOADER_WEIGHT_BCAST_EN (see npu_buf_loader.sv).

package npu_loader_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_BIAS   = 3'd1;
   localparam state_t ST_WEIGHT = 3'd2;
   localparam state_t ST_INPUT  = 3'd3;
   localparam state_t ST_DONE   = 3'd4;

   // Number of lanes needed to hold a value of bits_w bits.
   function automatic int bias_lanes(input int bits_w, input int data_w);
      return (bits_w + data_w - 1) / data_w;
   endfunction

   // Default geometry, used for the package-level masks below.
   localparam int DEF_LANES  = 9;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_BIAS_W = 16;

   localparam int BIAS_LANES = bias_lanes(DEF_BIAS_W, DEF_DATA_W);

   // Lane 0 sits in the MSB of en_in, so the bias lanes are the top bits.
   localparam logic [DEF_LANES-1:0] BIAS_EN_MASK =
      DEF_LANES'(((1 << BIAS_LANES) - 1) << (DEF_LANES - BIAS_LANES));

   localparam logic [DEF_LANES-1:0] LANE_ALL_ONES = '1;

endpackage

// File: rtl/npu_loader_addr_gen.sv
// npu_loader_addr_gen: row / beat / column counters for the buffer loader.
// Row stepping wraps after HEIGHT rows; beat stepping wraps after i_beats beats
// and carries into the row. The column is a running sum of LANES per beat so no
// multiplier is needed.

module npu_loader_addr_gen #(
   parameter int HEIGHT = 8,
   parameter int H_B    = 3,
   parameter int W_B    = 7,
   parameter int LANES  = 9
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           i_clr,
   input  logic           i_step_row,
   input  logic           i_step_beat,
   input  logic [W_B-1:0] i_beats,
   output logic [H_B-1:0] o_row,
   output logic [W_B-1:0] o_col,
   output logic           o_last_row,
   output logic           o_last_beat
);

   logic [H_B-1:0] r_row;
   logic [W_B-1:0] r_beat;
   logic [W_B-1:0] r_col;

   assign o_row       = r_row;
   assign o_col       = r_col;
   assign o_last_row  = (r_row == H_B'(HEIGHT - 1));
   assign o_last_beat = (r_beat == (i_beats - W_B'(1)));

   // Advance counters; a row wrap also returns the beat/column to the row start.
   always_ff @(posedge clk) begin
      if (!reset || i_clr) begin
         r_row  <= '0;
         r_beat <= '0;
         r_col  <= '0;
      end else if (i_step_beat) begin
         if (o_last_beat) begin
            r_beat <= '0;
            r_col  <= '0;
            r_row  <= o_last_row ? '0 : r_row + H_B'(1);
         end else begin
            r_beat <= r_beat + W_B'(1);
            r_col  <= r_col + W_B'(LANES);
         end
      end else if (i_step_row) begin
         r_row <= o_last_row ? '0 : r_row + H_B'(1);
      end
   end

endmodule

// File: rtl/npu_buf_loader.sv
// npu_buf_loader: fills the npu_simple operand buffer from a valid/ready stream,
// writing bias column, then weight column, then the input rows.
// Build option NPU_LOADER_WEIGHT_BCAST_EN: one weight beat is replicated to all
// rows instead of taking one beat per row.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_BIAS   | one beat per row, written to the bias column
// ST_WEIGHT | weight column for every row (broadcast or one beat per row)
// ST_INPUT  | cfg_in_beats beats per row, row-major, column = beat*LANES
// ST_DONE   | one cycle; raises done and drops busy on the way to IDLE

module npu_buf_loader
   import npu_loader_pkg::*;
#(
   parameter int WIDTH      = 80,
   parameter int HEIGHT     = 8,
   parameter int W_B        = 7,
   parameter int H_B        = 3,
   parameter int LANES      = 9,
   parameter int DATA_W     = 8,
   parameter int BIAS_W     = 16,
   parameter int WEIGHT_COL = WIDTH - LANES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [W_B-1:0]          cfg_in_beats,
   input  logic [LANES-1:0]        cfg_last_mask,
   input  logic [LANES*DATA_W-1:0] s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [W_B-1:0]          write_w,
   output logic [H_B-1:0]          write_h,
   output logic [LANES*DATA_W-1:0] data_in,
   output logic [LANES-1:0]        en_in,
   output logic                    busy,
   output logic                    done
);

   localparam int DW      = LANES * DATA_W;
   localparam int BIAS_LN = bias_lanes(BIAS_W, DATA_W);
   localparam logic [LANES-1:0] L_BIAS_EN =
      LANES'(((1 << BIAS_LN) - 1) << (LANES - BIAS_LN));
   localparam logic [LANES-1:0] L_ALL_EN = '1;

   state_t           r_state;
   logic [W_B-1:0]   r_cfg_beats;
   logic [LANES-1:0] r_cfg_mask;
   logic [W_B-1:0]   r_write_w;
   logic [H_B-1:0]   r_write_h;
   logic [DW-1:0]    r_data_in;
   logic [LANES-1:0] r_en_in;
   logic             r_busy;
   logic             r_done;
`ifdef NPU_LOADER_WEIGHT_BCAST_EN
   logic             r_wt_taken;
`endif

   logic             w_s_ready;
   logic             w_fire;
   logic             w_clr;
   logic             w_step_row;
   logic             w_step_beat;
   logic [H_B-1:0]   w_row;
   logic [W_B-1:0]   w_col;
   logic             w_last_row;
   logic             w_last_beat;
   logic [DW-1:0]    w_bias_data;

   assign s_ready = w_s_ready;
   assign write_w = r_write_w;
   assign write_h = r_write_h;
   assign data_in = r_data_in;
   assign en_in   = r_en_in;
   assign busy    = r_busy;
   assign done    = r_done;

   assign w_fire      = s_valid & w_s_ready;
   assign w_bias_data = DW'(s_data[BIAS_W-1:0]) << (DW - BIAS_W);

   // Ready decode; gated by reset so no beat is taken in a cycle being reset.
   always_comb begin
      w_s_ready = 1'b0;
      case (r_state)
         ST_BIAS, ST_INPUT: w_s_ready = 1'b1;
`ifdef NPU_LOADER_WEIGHT_BCAST_EN
         ST_WEIGHT:         w_s_ready = ~r_wt_taken;
`else
         ST_WEIGHT:         w_s_ready = 1'b1;
`endif
         default:           w_s_ready = 1'b0;
      endcase
      w_s_ready = w_s_ready & reset;
   end

   // Counter control: clear on an accepted start, step on every write issued.
   always_comb begin
      w_clr       = (r_state == ST_IDLE) & start;
      w_step_beat = (r_state == ST_INPUT) & w_fire;
`ifdef NPU_LOADER_WEIGHT_BCAST_EN
      w_step_row  = ((r_state == ST_BIAS) & w_fire) |
                    ((r_state == ST_WEIGHT) & (w_fire | r_wt_taken));
`else
      w_step_row  = ((r_state == ST_BIAS) | (r_state == ST_WEIGHT)) & w_fire;
`endif
   end

   npu_loader_addr_gen #(
      .HEIGHT (HEIGHT),
      .H_B    (H_B),
      .W_B    (W_B),
      .LANES  (LANES)
   ) u_addr_gen (
      .clk         (clk),
      .reset       (reset),
      .i_clr       (w_clr),
      .i_step_row  (w_step_row),
      .i_step_beat (w_step_beat),
      .i_beats     (r_cfg_beats),
      .o_row       (w_row),
      .o_col       (w_col),
      .o_last_row  (w_last_row),
      .o_last_beat (w_last_beat)
   );

   // Sequencer and registered buffer write port; en_in defaults to no write.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_cfg_beats <= '0;
         r_cfg_mask  <= '0;
         r_write_w   <= '0;
         r_write_h   <= '0;
         r_data_in   <= '0;
         r_en_in     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef NPU_LOADER_WEIGHT_BCAST_EN
         r_wt_taken  <= 1'b0;
`endif
      end else begin
         r_en_in <= '0;
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  // A zero beat count would never reach a last beat.
                  r_cfg_beats <= (cfg_in_beats == '0) ? W_B'(1) : cfg_in_beats;
                  r_cfg_mask  <= cfg_last_mask;
                  r_busy      <= 1'b1;
                  r_state     <= ST_BIAS;
               end
            end
            ST_BIAS: begin
               if (w_fire) begin
                  r_write_w <= W_B'(WIDTH);
                  r_write_h <= w_row;
                  r_data_in <= w_bias_data;
                  r_en_in   <= L_BIAS_EN;
                  if (w_last_row) r_state <= ST_WEIGHT;
               end
            end
            ST_WEIGHT: begin
`ifdef NPU_LOADER_WEIGHT_BCAST_EN
               // The single beat stays in data_in while rows 1.. are written.
               if (w_fire || r_wt_taken) begin
                  r_write_w <= W_B'(WEIGHT_COL);
                  r_write_h <= w_row;
                  r_en_in   <= L_ALL_EN;
                  if (w_fire) r_data_in <= s_data;
                  if (w_last_row) begin
                     r_wt_taken <= 1'b0;
                     r_state    <= ST_INPUT;
                  end else begin
                     r_wt_taken <= 1'b1;
                  end
               end
`else
               if (w_fire) begin
                  r_write_w <= W_B'(WEIGHT_COL);
                  r_write_h <= w_row;
                  r_data_in <= s_data;
                  r_en_in   <= L_ALL_EN;
                  if (w_last_row) r_state <= ST_INPUT;
               end
`endif
            end
            ST_INPUT: begin
               if (w_fire) begin
                  r_write_w <= w_col;
                  r_write_h <= w_row;
                  r_data_in <= s_data;
                  r_en_in   <= w_last_beat ? r_cfg_mask : L_ALL_EN;
                  if (w_last_beat && w_last_row) r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_npu_buf_loader.sv
// tb_npu_buf_loader: directed bench for npu_buf_loader at default geometry.
// Expected write lists are built from the intended load order; the weight phase
// expectation follows NPU_LOADER_WEIGHT_BCAST_EN as the DUT is built.

module tb_npu_buf_loader;

   localparam int WIDTH  = 80;
   localparam int HEIGHT = 8;
   localparam int W_B    = 7;
   localparam int H_B    = 3;
   localparam int LANES  = 9;
   localparam int DATA_W = 8;
   localparam int BIAS_W = 16;
   localparam int DW     = LANES * DATA_W;
   localparam int REC_W  = W_B + H_B + DW + LANES;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [W_B-1:0]   cfg_in_beats = '0;
   logic [LANES-1:0] cfg_last_mask = '0;
   logic [DW-1:0]    s_data = '0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [W_B-1:0]   write_w;
   logic [H_B-1:0]   write_h;
   logic [DW-1:0]    data_in;
   logic [LANES-1:0] en_in;
   logic             busy;
   logic             done;

   npu_buf_loader #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .W_B(W_B), .H_B(H_B),
      .LANES(LANES), .DATA_W(DATA_W), .BIAS_W(BIAS_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_in_beats(cfg_in_beats), .cfg_last_mask(cfg_last_mask),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .write_w(write_w), .write_h(write_h), .data_in(data_in), .en_in(en_in),
      .busy(busy), .done(done)
   );

   // Free-running clock, 10 time units period.
   always #5 clk = ~clk;

   int cyc = 0;
   // Cycle counter used to time done against the last write.
   always @(posedge clk) cyc++;

   logic [REC_W-1:0] wr_q[$];
   logic [REC_W-1:0] exp_q[$];
   int   done_cnt = 0;
   int   done_cyc = 0;
   int   last_wr_cyc = 0;
   logic done_busy = 1'b0;
   logic busy_after_start = 1'b0;
   int   k_beats = 0;
   int   exp_beats = 0;
   int   vectors = 0;
   int   errors = 0;

   // Record every buffer write and every done pulse, sampled mid-cycle.
   always @(negedge clk) begin
      if (en_in != '0) begin
         wr_q.push_back({write_w, write_h, data_in, en_in});
         last_wr_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_busy = busy;
      end
   end

   function automatic logic [DW-1:0] beat_data(input int k);
      logic [DW-1:0] d;
      for (int l = 0; l < LANES; l++) d[DW-1-8*l -: 8] = 8'(k * 11 + l);
      return d;
   endfunction

   task automatic build_exp(input int beats, input logic [LANES-1:0] mask);
      logic [DW-1:0] d;
      int k;
      int nb;
      exp_q.delete();
      k = 0;
      for (int r = 0; r < HEIGHT; r++) begin
         d = beat_data(k);
         k++;
         exp_q.push_back({W_B'(80), H_B'(r), {d[15:0], 56'h0}, 9'h180});
      end
`ifdef NPU_LOADER_WEIGHT_BCAST_EN
      d = beat_data(k);
      k++;
      for (int r = 0; r < HEIGHT; r++) exp_q.push_back({W_B'(71), H_B'(r), d, 9'h1FF});
`else
      for (int r = 0; r < HEIGHT; r++) begin
         d = beat_data(k);
         k++;
         exp_q.push_back({W_B'(71), H_B'(r), d, 9'h1FF});
      end
`endif
      nb = (beats == 0) ? 1 : beats;
      for (int r = 0; r < HEIGHT; r++) begin
         for (int b = 0; b < nb; b++) begin
            d = beat_data(k);
            k++;
            exp_q.push_back({W_B'(b * 9), H_B'(r), d, (b == nb - 1) ? mask : 9'h1FF});
         end
      end
      exp_beats = k;
   endtask

   // Start a load and stream beats until done, a write count, or the budget.
   task automatic run_load(input int beats, input logic [LANES-1:0] mask,
                           input bit toggle, input int extra1, input int extra2,
                           input int abort_wr);
      wr_q.delete();
      done_cnt = 0;
      k_beats  = 0;
      @(negedge clk); #1;
      cfg_in_beats  = W_B'(beats);
      cfg_last_mask = mask;
      s_valid       = 1'b0;
      start         = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      busy_after_start = busy;
      for (int n = 0; n < 400; n++) begin
         if (done_cnt > 0 || (abort_wr > 0 && wr_q.size() >= abort_wr)) break;
         s_valid = toggle ? (n % 2 == 0) : 1'b1;
         s_data  = beat_data(k_beats);
         start   = (n == extra1 || n == extra2);
         if (s_valid && s_ready) k_beats++;
         @(negedge clk); #1;
      end
      start = 1'b0;
      if (abort_wr == 0) begin
         s_valid = 1'b0;
         repeat (4) @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      vectors++; if (en_in !== 9'h0) begin errors++; $display("FAIL reset_en_in got %h want 0", en_in); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
      vectors++; if (write_w !== 7'h0) begin errors++; $display("FAIL reset_write_w got %h want 0", write_w); end
      vectors++; if (write_h !== 3'h0) begin errors++; $display("FAIL reset_write_h got %h want 0", write_h); end
      vectors++; if (data_in !== 72'h0) begin errors++; $display("FAIL reset_data_in got %h want 0", data_in); end
      reset = 1'b1;
      @(negedge clk); #1;
      vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL idle_s_ready got %b want 0", s_ready); end
   endtask

   // Full load; used for continuous, stalled and start-while-busy scenarios.
   task automatic test_load(input string tag, input int beats, input logic [LANES-1:0] mask,
                            input bit toggle, input int extra1, input int extra2);
      logic [REC_W-1:0] act;
      build_exp(beats, mask);
      run_load(beats, mask, toggle, extra1, extra2, 0);
      vectors++;
      if (busy_after_start !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got %b want 1", tag, busy_after_start); end
      vectors++;
      if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL %s write_count got %0d want %0d", tag, wr_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         act = (i < wr_q.size()) ? wr_q[i] : 'x;
         vectors++;
         if (act !== exp_q[i]) begin errors++; $display("FAIL %s write[%0d] got %h want %h", tag, i, act, exp_q[i]); end
      end
      vectors++;
      if (k_beats != exp_beats) begin errors++; $display("FAIL %s beats_consumed got %0d want %0d", tag, k_beats, exp_beats); end
      vectors++;
      if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses got %0d want 1", tag, done_cnt); end
      vectors++;
      if (done_cyc != last_wr_cyc + 1) begin errors++; $display("FAIL %s done_cycle got %0d want %0d", tag, done_cyc, last_wr_cyc + 1); end
      vectors++;
      if (done_busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", tag, done_busy); end
   endtask

   task automatic test_reset_mid();
      logic [REC_W-1:0] act;
      run_load(8, 9'h1FE, 1'b0, -1, -1, 42);
      reset = 1'b0;
      @(negedge clk); #1;
      vectors++; if (en_in !== 9'h0) begin errors++; $display("FAIL midreset_en_in got %h want 0", en_in); end
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
      vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midreset_s_ready got %b want 0", s_ready); end
      reset   = 1'b1;
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midreset_idle_s_ready got %b want 0", s_ready); end
      vectors++; if (done_cnt != 0) begin errors++; $display("FAIL midreset_done_pulses got %0d want 0", done_cnt); end
      build_exp(8, 9'h1FE);
      run_load(8, 9'h1FE, 1'b0, -1, -1, 0);
      act = (wr_q.size() > 0) ? wr_q[0] : 'x;
      vectors++; if (act !== exp_q[0]) begin errors++; $display("FAIL restart_first_write got %h want %h", act, exp_q[0]); end
      vectors++; if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL restart_write_count got %0d want %0d", wr_q.size(), exp_q.size()); end
      vectors++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_load("continuous", 8, 9'h1FE, 1'b0, -1, -1);
      test_load("stalled", 8, 9'h1FE, 1'b1, -1, -1);
      test_load("start_busy", 8, 9'h1FE, 1'b0, 30, 80);
      test_reset_mid();
      test_load("one_beat", 1, 9'h1C0, 1'b0, -1, -1);
      test_load("zero_beat", 0, 9'h1C0, 1'b0, -1, -1);
      test_load("three_beat_stall", 3, 9'h100, 1'b1, -1, -1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
